// File: rtl/lsu_pkg.sv
// Shared encodings for the load/store unit: access sizes, FSM states, lane count.
package lsu_pkg;
  localparam int LANES = 4;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10,
    SZ_RSVD = 2'b11
  } size_e;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_ACCESS = 2'b01,
    ST_MERGE  = 2'b10,
    ST_RESP   = 2'b11
  } state_e;

  // Reserved size or an address not aligned to the access size.
  function automatic logic access_err(input logic [1:0] size, input logic [1:0] off);
    return (size == SZ_RSVD) ||
           ((size == SZ_HALF) && off[0]) ||
           ((size == SZ_WORD) && (off != 2'b00));
  endfunction
endpackage

// File: rtl/lsu_lane.sv
// Byte-lane datapath: load extract/extend and sub-word store merge into an old word.
module lsu_lane
  import lsu_pkg::*;
(
  input  logic [LANES*8-1:0] i_word,
  input  logic [LANES*8-1:0] i_new,
  input  logic [1:0]         i_off,
  input  logic [1:0]         i_size,
  input  logic               i_unsigned,
  output logic [LANES*8-1:0] o_load,
  output logic [LANES*8-1:0] o_merged
);
  logic [LANES*8-1:0] w_shift;
  logic [LANES*8-1:0] w_mask;
  logic [LANES*8-1:0] w_data;
  logic [4:0]         w_bits;

  assign w_bits  = {i_off, 3'b000};
  assign w_shift = i_word >> w_bits;
  assign w_data  = i_new << w_bits;

  always_comb begin
    o_load = w_shift;
    w_mask = '1;
    case (i_size)
      SZ_BYTE: begin
        o_load = {{24{~i_unsigned & w_shift[7]}}, w_shift[7:0]};
        w_mask = 32'h0000_00FF << w_bits;
      end
      SZ_HALF: begin
        o_load = {{16{~i_unsigned & w_shift[15]}}, w_shift[15:0]};
        w_mask = 32'h0000_FFFF << w_bits;
      end
      default: begin
        o_load = i_word;
        w_mask = '1;
      end
    endcase
  end

  assign o_merged = (i_word & ~w_mask) | (w_data & w_mask);
endmodule

// File: rtl/lsu.sv
// Load/store unit: one request at a time, word-only memory, RMW for sub-word stores.
// Optional saturating response counters when LSU_STATS_EN is defined.
// Handshakes: a transfer happens on a rising edge where valid && ready are both high.
module lsu
  import lsu_pkg::*;
#(
  parameter int A_WIDTH = 32,
  parameter int D_WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic               req_we,
  input  logic [1:0]         req_size,
  input  logic               req_unsigned,
  input  logic [A_WIDTH-1:0] req_addr,
  input  logic [D_WIDTH-1:0] req_wdata,
  output logic               resp_valid,
  input  logic               resp_ready,
  output logic [D_WIDTH-1:0] resp_rdata,
  output logic               resp_err,
  output logic               mem_we,
  output logic [A_WIDTH-1:0] mem_w_addr,
  output logic [D_WIDTH-1:0] mem_w_data,
  output logic               mem_re,
  output logic [A_WIDTH-1:0] mem_r_addr,
  input  logic [D_WIDTH-1:0] mem_r_data,
`ifdef LSU_STATS_EN
  output logic [15:0]        stat_loads,
  output logic [15:0]        stat_stores,
  output logic [15:0]        stat_errs,
`endif
  output logic [1:0]         dbg_state
);
  state_e             r_state, w_next;
  logic               r_we, r_unsigned;
  logic [1:0]         r_size;
  logic [A_WIDTH-1:0] r_addr;
  logic [D_WIDTH-1:0] r_wdata, r_merged, r_rdata;
  logic               r_err;
  logic               w_err, w_accept, w_sub_store;
  logic [D_WIDTH-1:0] w_load, w_merged;
  logic [A_WIDTH-1:0] w_aligned;

  assign w_err       = access_err(r_size, r_addr[1:0]);
  assign w_accept    = req_valid && req_ready;
  assign w_sub_store = r_we && (r_size != SZ_WORD);
  assign w_aligned   = {r_addr[A_WIDTH-1:2], 2'b00};

  lsu_lane u_lane (
    .i_word     (mem_r_data),
    .i_new      (r_wdata),
    .i_off      (r_addr[1:0]),
    .i_size     (r_size),
    .i_unsigned (r_unsigned),
    .o_load     (w_load),
    .o_merged   (w_merged)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= ST_IDLE;
    else      r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:   if (req_valid) w_next = ST_ACCESS;
      ST_ACCESS: w_next = (!w_err && w_sub_store) ? ST_MERGE : ST_RESP;
      ST_MERGE:  w_next = ST_RESP;
      ST_RESP:   if (resp_ready) w_next = ST_IDLE;
      default:   w_next = ST_IDLE;
    endcase
  end

  // Strobes decode from state alone, so an async reset drops them immediately.
  always_comb begin
    req_ready  = (r_state == ST_IDLE);
    resp_valid = (r_state == ST_RESP);
    mem_re     = (r_state == ST_ACCESS) && !w_err && (!r_we || w_sub_store);
    mem_we     = ((r_state == ST_ACCESS) && !w_err && r_we && !w_sub_store) ||
                 (r_state == ST_MERGE);
    mem_w_data = (r_state == ST_MERGE) ? r_merged : r_wdata;
  end

  assign mem_w_addr = w_aligned;
  assign mem_r_addr = w_aligned;
  assign resp_rdata = r_rdata;
  assign resp_err   = r_err;
  assign dbg_state  = r_state;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_we       <= 1'b0;
      r_unsigned <= 1'b0;
      r_size     <= 2'b00;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_merged   <= '0;
      r_rdata    <= '0;
      r_err      <= 1'b0;
    end else if (w_accept) begin
      r_we       <= req_we;
      r_unsigned <= req_unsigned;
      r_size     <= req_size;
      r_addr     <= req_addr;
      r_wdata    <= req_wdata;
      r_rdata    <= '0;
      r_err      <= 1'b0;
    end else if (r_state == ST_ACCESS) begin
      r_err    <= w_err;
      r_rdata  <= (w_err || r_we) ? '0 : w_load;
      r_merged <= w_merged;
    end
  end

`ifdef LSU_STATS_EN
  logic w_done;
  assign w_done = resp_valid && resp_ready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stat_loads  <= '0;
      stat_stores <= '0;
      stat_errs   <= '0;
    end else if (w_done) begin
      if (r_err) begin
        if (stat_errs != 16'hFFFF) stat_errs <= stat_errs + 16'd1;
      end else if (r_we) begin
        if (stat_stores != 16'hFFFF) stat_stores <= stat_stores + 16'd1;
      end else begin
        if (stat_loads != 16'hFFFF) stat_loads <= stat_loads + 16'd1;
      end
    end
  end
`endif
endmodule
